// File: rtl/systolic_output_collector.sv
// systolic_output_collector
//
// Receive side of the systolic matmul output interface. Each bottom_out lane
// delivers one result column, ROWS words long, possibly skewed in time against
// the other lanes. A per-lane row counter places every valid word at
// (wr_row[c], c) of a row-major ROWS x COLS matrix. When every lane has
// delivered ROWS words the block enters DONE, pulses done and holds
// result_valid until the next start.
//
// Ports
//   clk              : clock, all sampling on posedge
//   rst              : asynchronous active-high reset
//   start            : 1-cycle pulse, clears the matrix and flags, arms COLLECT
//   bottom_out       : COLS lanes of WORD_SIZE bits, lane c at [c*WORD_SIZE +: WORD_SIZE]
//   output_col_valid : per-lane valid
//   result_matrix    : element (r,c) at [(r*COLS+c)*WORD_SIZE +: WORD_SIZE]
//   result_valid     : level, matrix complete and stable (state DONE)
//   done             : 1-cycle pulse on entry to DONE
//   busy             : high while in COLLECT
//   col_overflow     : sticky, lane c delivered more than ROWS words
//   stray_valid      : sticky, a valid arrived outside COLLECT
//   timeout_err      : sticky, COLLECT ran TIMEOUT cycles without completing
module systolic_output_collector #(
  parameter int WORD_SIZE = 16,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [COLS*WORD_SIZE-1:0]      bottom_out,
  input  logic [COLS-1:0]                output_col_valid,
  output logic [ROWS*COLS*WORD_SIZE-1:0] result_matrix,
  output logic                           result_valid,
  output logic                           done,
  output logic                           busy,
  output logic [COLS-1:0]                col_overflow,
  output logic                           stray_valid,
  output logic                           timeout_err
);

  // One spare bit so that ROWS and TIMEOUT themselves are representable.
  localparam int CW = $clog2(ROWS) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                         state_reg, state_next;
  logic [CW-1:0]                  wr_row_reg [COLS];
  logic [TW-1:0]                  cyc_reg;
  logic [ROWS*COLS*WORD_SIZE-1:0] matrix_reg;
  logic [COLS-1:0]                overflow_reg;
  logic                           stray_reg;
  logic                           timeout_reg;
  logic                           done_reg;

  // start overrides everything in its cycle, so valids are not sampled then.
  logic            collecting;
  logic [COLS-1:0] lane_fire;       // word accepted and stored
  logic [COLS-1:0] lane_ovf;        // word arrived on an already full lane
  logic [COLS-1:0] lane_full_next;  // lane holds ROWS words after this edge
  logic            all_full_next;
  logic            timeout_hit;

  assign collecting = (state_reg == S_COLLECT) && !start;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_lane
      assign lane_fire[gi] = collecting && output_col_valid[gi] && (wr_row_reg[gi] < ROWS_C);
      assign lane_ovf[gi]  = collecting && output_col_valid[gi] && (wr_row_reg[gi] >= ROWS_C);
      // Looking one edge ahead lets DONE follow the last stored word by one clock.
      assign lane_full_next[gi] = (wr_row_reg[gi] >= ROWS_C) ||
                                  (lane_fire[gi] && (wr_row_reg[gi] == ROWS_C - CW'(1)));
    end
  endgenerate

  assign all_full_next = &lane_full_next;
  // Completion in the final permitted cycle takes priority over the timeout.
  assign timeout_hit   = collecting && !all_full_next && (cyc_reg >= T_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = S_COLLECT;
    end else begin
      case (state_reg)
        S_COLLECT: begin
          if (all_full_next) begin
            state_next = S_DONE;
          end else if (timeout_hit) begin
            state_next = S_IDLE;
          end
        end
        S_DONE:  state_next = S_DONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy          = (state_reg == S_COLLECT);
    result_valid  = (state_reg == S_DONE);
    done          = done_reg;
    result_matrix = matrix_reg;
    col_overflow  = overflow_reg;
    stray_valid   = stray_reg;
    timeout_err   = timeout_reg;
  end

  // Datapath: matrix, counters and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      matrix_reg   <= '0;
      cyc_reg      <= '0;
      overflow_reg <= '0;
      stray_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
      done_reg     <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        wr_row_reg[c] <= '0;
      end
    end else if (start) begin
      matrix_reg   <= '0;
      cyc_reg      <= '0;
      overflow_reg <= '0;
      stray_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
      done_reg     <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        wr_row_reg[c] <= '0;
      end
    end else begin
      done_reg <= (state_reg == S_COLLECT) && (state_next == S_DONE);

      if ((state_reg != S_COLLECT) && (|output_col_valid)) begin
        stray_reg <= 1'b1;
      end

      if (state_reg == S_COLLECT) begin
        cyc_reg <= cyc_reg + TW'(1);
      end

      if (timeout_hit) begin
        timeout_reg <= 1'b1;
      end

      for (int c = 0; c < COLS; c++) begin
        if (lane_fire[c]) begin
          matrix_reg[(int'(wr_row_reg[c]) * COLS + c) * WORD_SIZE +: WORD_SIZE]
            <= bottom_out[c * WORD_SIZE +: WORD_SIZE];
          wr_row_reg[c] <= wr_row_reg[c] + CW'(1);
        end
        if (lane_ovf[c]) begin
          overflow_reg[c] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_output_collector.sv
module tb_systolic_output_collector;

  localparam int W = 16;
  localparam int R = 4;
  localparam int C = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [C*W-1:0]   bottom_out;
  logic [C-1:0]     output_col_valid;
  logic [R*C*W-1:0] result_matrix;
  logic             result_valid;
  logic             done;
  logic             busy;
  logic [C-1:0]     col_overflow;
  logic             stray_valid;
  logic             timeout_err;

  int checks;
  int failures;

  systolic_output_collector #(
    .WORD_SIZE(W), .ROWS(R), .COLS(C), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bottom_out(bottom_out),
    .output_col_valid(output_col_valid), .result_matrix(result_matrix),
    .result_valid(result_valid), .done(done), .busy(busy),
    .col_overflow(col_overflow), .stray_valid(stray_valid), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] elem(input int r, input int c);
    return result_matrix[(r * C + c) * W +: W];
  endfunction

  // One clock with the given valid mask; idle lanes carry junk to expose gating bugs.
  task automatic cyc(input logic [C-1:0] v, input logic [C*W-1:0] d);
    output_col_valid = v;
    bottom_out       = d;
    tick();
    output_col_valid = '0;
    bottom_out       = {C{16'hBEEF}};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // All lanes valid together for R cycles, word = base + 16*r + c.
  task automatic stream_aligned(input logic [W-1:0] base);
    logic [C*W-1:0] d;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) d[c*W +: W] = base + W'(16 * r + c);
      cyc('1, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; output_col_valid = '0; bottom_out = '0;
    #23;
    rst = 1'b0;
    tick();
    checks++;
    if ({result_valid, done, busy, col_overflow, stray_valid, timeout_err} !== '0 || result_matrix !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rv=%b done=%b busy=%b ovf=%b stray=%b to=%b mat=%h required all 0",
               result_valid, done, busy, col_overflow, stray_valid, timeout_err, result_matrix);
    end
  endtask

  task automatic test_stray_before_start();
    cyc(4'b0001, {C{16'h5A5A}});
    checks++;
    if (stray_valid !== 1'b1 || result_matrix !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_idle got stray=%b busy=%b mat=%h required stray=1 busy=0 mat=0",
               stray_valid, busy, result_matrix);
    end
  endtask

  task automatic test_skewed();
    logic [C-1:0]   v;
    logic [C*W-1:0] d;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || stray_valid !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL skew_armed got busy=%b stray=%b rv=%b required busy=1 stray=0 rv=0",
               busy, stray_valid, result_valid);
    end
    for (int k = 1; k <= 7; k++) begin
      v = '0;
      d = {C{16'hBEEF}};
      for (int c = 0; c < C; c++) begin
        if (k - c - 1 >= 0 && k - c - 1 < R) begin
          v[c] = 1'b1;
          d[c*W +: W] = W'(16 * (k - c - 1) + c);
        end
      end
      cyc(v, d);
      if (k == 6) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL skew_early_done got done=%b busy=%b required done=0 busy=1", done, busy);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || result_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL skew_done got done=%b rv=%b busy=%b required 1 1 0", done, result_valid, busy);
    end
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        checks++;
        if (elem(r, c) !== W'(16 * r + c)) begin
          failures++;
          $display("FAIL skew_elem(%0d,%0d) got %h required %h", r, c, elem(r, c), W'(16 * r + c));
        end
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || result_valid !== 1'b1 || col_overflow !== '0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL skew_hold got done=%b rv=%b ovf=%b to=%b required 0 1 0000 0",
               done, result_valid, col_overflow, timeout_err);
    end
  endtask

  task automatic test_stray_after_done();
    logic [W-1:0] e00;
    e00 = elem(0, 0);
    cyc(4'b0001, {C{16'hFFFF}});
    checks++;
    if (stray_valid !== 1'b1 || elem(0, 0) !== 16'h0000 || e00 !== 16'h0000 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL stray_done got stray=%b e00=%h rv=%b required stray=1 e00=0000 rv=1",
               stray_valid, elem(0, 0), result_valid);
    end
  endtask

  task automatic test_aligned();
    pulse_start();
    checks++;
    if (result_matrix !== '0 || result_valid !== 1'b0 || stray_valid !== 1'b0) begin
      failures++;
      $display("FAIL aligned_clear got mat=%h rv=%b stray=%b required 0", result_matrix, result_valid, stray_valid);
    end
    stream_aligned(16'h0000);
    checks++;
    if (done !== 1'b1 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL aligned_done got done=%b rv=%b required 1 1", done, result_valid);
    end
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        checks++;
        if (elem(r, c) !== W'(16 * r + c)) begin
          failures++;
          $display("FAIL aligned_elem(%0d,%0d) got %h required %h", r, c, elem(r, c), W'(16 * r + c));
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [C-1:0]   v;
    logic [C*W-1:0] d;
    pulse_start();
    // Lanes 0,1: cycles 1-4. Lane 2: cycles 1-5 (five words). Lane 3: cycles 2-5.
    for (int k = 1; k <= 5; k++) begin
      v = '0;
      d = {C{16'hBEEF}};
      if (k <= 4) begin
        v[0] = 1'b1; d[0*W +: W] = W'(16'h0300 + k - 1);
        v[1] = 1'b1; d[1*W +: W] = W'(16'h0310 + k - 1);
      end
      v[2] = 1'b1; d[2*W +: W] = W'(16'h00A0 + k - 1);
      if (k >= 2) begin
        v[3] = 1'b1; d[3*W +: W] = W'(16'h0330 + k - 2);
      end
      cyc(v, d);
    end
    checks++;
    if (col_overflow !== 4'b0100 || done !== 1'b1 || result_valid !== 1'b1 || stray_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_flags got ovf=%b done=%b rv=%b stray=%b required 0100 1 1 0",
               col_overflow, done, result_valid, stray_valid);
    end
    for (int r = 0; r < R; r++) begin
      checks++;
      if (elem(r, 2) !== W'(16'h00A0 + r) || elem(r, 3) !== W'(16'h0330 + r)) begin
        failures++;
        $display("FAIL ovf_col row%0d got c2=%h c3=%h required %h %h",
                 r, elem(r, 2), elem(r, 3), W'(16'h00A0 + r), W'(16'h0330 + r));
      end
    end
  endtask

  task automatic test_timeout();
    logic [C*W-1:0] d;
    pulse_start();
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) d[c*W +: W] = W'(16'h0400 + 16 * r + c);
      cyc((r < 3) ? 4'b1111 : 4'b0111, d);
    end
    for (int n = 4; n < 63; n++) tick();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early at cycle 63 got to=%b busy=%b required 0 1", timeout_err, busy);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire at cycle 64 got to=%b busy=%b rv=%b done=%b required 1 0 0 0",
               timeout_err, busy, result_valid, done);
    end
    checks++;
    if (elem(0, 0) !== 16'h0400 || elem(3, 2) !== 16'h0432 || elem(3, 3) !== 16'h0000) begin
      failures++;
      $display("FAIL timeout_partial got e00=%h e32=%h e33=%h required 0400 0432 0000",
               elem(0, 0), elem(3, 2), elem(3, 3));
    end
  endtask

  task automatic test_back_to_back();
    logic [C*W-1:0] d;
    pulse_start();
    stream_aligned(16'h0600);
    // Restart while the previous result is being presented.
    pulse_start();
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) d[c*W +: W] = W'(16'h0700 + 16 * r + c);
      if (r == R - 1) start = 1'b1;  // start coincides with completion
      cyc('1, d);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || result_valid !== 1'b0 || result_matrix !== '0) begin
      failures++;
      $display("FAIL start_wins got busy=%b done=%b rv=%b mat=%h required 1 0 0 0",
               busy, done, result_valid, result_matrix);
    end
    stream_aligned(16'h0800);
    checks++;
    if (done !== 1'b1 || elem(2, 1) !== 16'h0821 || elem(3, 3) !== 16'h0833) begin
      failures++;
      $display("FAIL rearm got done=%b e21=%h e33=%h required 1 0821 0833", done, elem(2, 1), elem(3, 3));
    end
  endtask

  task automatic test_reset_mid_collect();
    logic [C*W-1:0] d;
    pulse_start();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < C; c++) d[c*W +: W] = W'(16'h0900 + 16 * r + c);
      cyc('1, d);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || result_matrix !== '0 || result_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got busy=%b rv=%b done=%b mat=%h required all 0",
               busy, result_valid, done, result_matrix);
    end
    tick();
    rst = 1'b0;
    pulse_start();
    stream_aligned(16'h0B00);
    checks++;
    if (done !== 1'b1 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_done got done=%b rv=%b required 1 1", done, result_valid);
    end
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        checks++;
        if (elem(r, c) !== W'(16'h0B00 + 16 * r + c)) begin
          failures++;
          $display("FAIL post_reset_elem(%0d,%0d) got %h required %h",
                   r, c, elem(r, c), W'(16'h0B00 + 16 * r + c));
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stray_before_start();
    test_skewed();
    test_stray_after_done();
    test_aligned();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid_collect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
